// File: rtl/companion_pkg.sv
// Shared definitions for the companion menu FSM and its action executor:
// action codes, executor state encoding and stat indexing.
package companion_pkg;

  // Action codes; companion_fsm drives these on its selected output.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'b00,
    ACT_FEED  = 2'b01,
    ACT_PLAY  = 2'b10,
    ACT_CLEAN = 2'b11
  } action_t;

  // Executor FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_DONE     = 2'b10,
    ST_WAIT_REL = 2'b11
  } exec_state_t;

  // Stat slots, in the order the stat register instances are generated.
  localparam int STAT_COUNT = 3;
  localparam int STAT_FULL  = 0;
  localparam int STAT_HAPPY = 1;
  localparam int STAT_CLEAN = 2;

  // Headroom bits for the stat update: one for the carry of old+inc,
  // one sign bit so an underflow is seen before it wraps.
  localparam int STAT_SUM_EXTRA = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input longint n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/companion_stat_reg.sv
// One saturating pet stat. Each edge it loads clamp(value + inc - dec, 0, STAT_MAX),
// so simultaneous boosts, costs and decay resolve in a single step.
module companion_stat_reg
  import companion_pkg::*;
#(
  parameter int STAT_W    = 4,
  parameter int STAT_MAX  = 15,
  parameter int STAT_INIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] inc,
  input  logic [STAT_W-1:0] dec,
  output logic [STAT_W-1:0] value
);

  localparam int SUM_W = STAT_W + STAT_SUM_EXTRA;
  localparam logic [SUM_W-1:0]  MAX_WIDE = SUM_W'(STAT_MAX);
  localparam logic [STAT_W-1:0] MAX_V    = STAT_W'(STAT_MAX);
  localparam logic [STAT_W-1:0] INIT_V   = STAT_W'(STAT_INIT);

  // Two's-complement sum in the widened format; the top bit is the sign.
  logic [SUM_W-1:0]  sum;
  logic [STAT_W-1:0] value_next;

  // Widened sum followed by clamping to [0, STAT_MAX].
  always_comb begin
    sum = SUM_W'(value) + SUM_W'(inc) - SUM_W'(dec);
    if (sum[SUM_W-1]) begin
      value_next = '0;
    end else if (sum > MAX_WIDE) begin
      value_next = MAX_V;
    end else begin
      value_next = sum[STAT_W-1:0];
    end
  end

  // Stat register, synchronous active-low reset to the initial value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= INIT_V;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/companion_action_exec.sv
// Action executor behind companion_fsm. Runs the latched action for a fixed
// number of cycles, applies its stat effect on completion, pulses exec_status,
// and waits for the request to drop before re-arming. Also owns stat decay and
// the needs_attention flag.
module companion_action_exec
  import companion_pkg::*;
#(
  parameter int          STAT_W        = 4,
  parameter int          STAT_MAX      = 15,
  parameter int          STAT_INIT     = 8,
  parameter int          BOOST         = 4,
  parameter int          PLAY_COST     = 1,
  parameter int unsigned ACTION_CYCLES = 50_000_000,
  parameter int unsigned DECAY_CYCLES  = 250_000_000,
  parameter int          LOW_THRESH    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        selected,
  input  logic              exec,
  output logic              exec_status,
  output logic              busy,
  output logic [STAT_W-1:0] fullness,
  output logic [STAT_W-1:0] happiness,
  output logic [STAT_W-1:0] cleanliness,
  output logic              needs_attention
);

  localparam int ACT_CNT_W = cnt_width(longint'(ACTION_CYCLES));
  localparam int DEC_CNT_W = cnt_width(longint'(DECAY_CYCLES));
  localparam logic [ACT_CNT_W-1:0] ACT_LAST = ACT_CNT_W'(ACTION_CYCLES - 1);
  localparam logic [DEC_CNT_W-1:0] DEC_LAST = DEC_CNT_W'(DECAY_CYCLES - 1);
  localparam logic [STAT_W-1:0]    BOOST_V  = STAT_W'(BOOST);
  localparam logic [STAT_W-1:0]    COST_V   = STAT_W'(PLAY_COST);
  localparam logic [STAT_W-1:0]    LOW_V    = STAT_W'(LOW_THRESH);

  exec_state_t          state_reg, state_next;
  action_t              act_reg, act_next;
  logic [ACT_CNT_W-1:0] act_cnt_reg, act_cnt_next;
  logic [DEC_CNT_W-1:0] dec_cnt_reg;
  logic                 busy_reg, busy_next;
  logic                 status_reg, status_next;
  logic                 attention_reg;

  // High on the edge that moves RUN -> DONE; the stat effect lands on that edge.
  logic complete;
  // High on the edge where the decay counter wraps.
  logic decay_tick;
  logic any_low;

  logic [STAT_W-1:0] stat_inc [STAT_COUNT];
  logic [STAT_W-1:0] stat_dec [STAT_COUNT];
  logic [STAT_W-1:0] stat_val [STAT_COUNT];

  assign decay_tick = (dec_cnt_reg == DEC_LAST);

  // Exec FSM next-state logic and the registered-output next values.
  always_comb begin
    state_next   = state_reg;
    act_next     = act_reg;
    act_cnt_next = act_cnt_reg;
    complete     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (exec) begin
          state_next   = ST_RUN;
          act_next     = action_t'(selected);
          act_cnt_next = '0;
        end
      end
      ST_RUN: begin
        // Request and selection are ignored here; the latched act is used.
        if (act_cnt_reg == ACT_LAST) begin
          state_next = ST_DONE;
          complete   = 1'b1;
        end else begin
          act_cnt_next = act_cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = exec ? ST_WAIT_REL : ST_IDLE;
      end
      ST_WAIT_REL: begin
        // Re-arm only once the requester releases exec.
        if (!exec) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next   = (state_next == ST_RUN);
    status_next = (state_next == ST_DONE);
  end

  // Exec FSM state, latched action, action counter and registered flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      act_reg     <= ACT_NONE;
      act_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      status_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      act_reg     <= act_next;
      act_cnt_reg <= act_cnt_next;
      busy_reg    <= busy_next;
      status_reg  <= status_next;
    end
  end

  // Free-running decay counter, independent of the exec FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_cnt_reg <= '0;
    end else if (decay_tick) begin
      dec_cnt_reg <= '0;
    end else begin
      dec_cnt_reg <= dec_cnt_reg + 1'b1;
    end
  end

  // Per-stat increments and decrements: decay on every stat, action effect on completion.
  always_comb begin
    for (int i = 0; i < STAT_COUNT; i++) begin
      stat_inc[i] = '0;
      stat_dec[i] = STAT_W'(decay_tick);
    end
    if (complete) begin
      case (act_reg)
        ACT_FEED: begin
          stat_inc[STAT_FULL] = BOOST_V;
        end
        ACT_PLAY: begin
          stat_inc[STAT_HAPPY] = BOOST_V;
          stat_dec[STAT_FULL]  = stat_dec[STAT_FULL] + COST_V;
        end
        ACT_CLEAN: begin
          stat_inc[STAT_CLEAN] = BOOST_V;
        end
        default: begin
        end
      endcase
    end
  end

  // One saturating register per stat.
  generate
    for (genvar gi = 0; gi < STAT_COUNT; gi++) begin : g_stat
      companion_stat_reg #(
        .STAT_W   (STAT_W),
        .STAT_MAX (STAT_MAX),
        .STAT_INIT(STAT_INIT)
      ) u_stat (
        .clk  (clk),
        .rst  (rst),
        .inc  (stat_inc[gi]),
        .dec  (stat_dec[gi]),
        .value(stat_val[gi])
      );
    end
  endgenerate

  // Low-stat detect on the current stat values.
  always_comb begin
    any_low = 1'b0;
    for (int i = 0; i < STAT_COUNT; i++) begin
      if (stat_val[i] < LOW_V) begin
        any_low = 1'b1;
      end
    end
  end

  // Registered needs_attention, one cycle behind the stats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      attention_reg <= 1'b0;
    end else begin
      attention_reg <= any_low;
    end
  end

  assign exec_status     = status_reg;
  assign busy            = busy_reg;
  assign fullness        = stat_val[STAT_FULL];
  assign happiness       = stat_val[STAT_HAPPY];
  assign cleanliness     = stat_val[STAT_CLEAN];
  assign needs_attention = attention_reg;

endmodule

// File: tb/tb_companion_action_exec.sv
// Bench for companion_action_exec: table-driven action sequences, directed
// decay / coincidence / abort cases, and a randomized run checked every cycle
// against an edge-indexed reference model.
module tb_companion_action_exec;

  localparam int AC     = 4;
  localparam int DEC_A  = 1000;
  localparam int DEC_B  = 10;
  localparam int DEC_C  = 6;
  localparam int SMAX   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: main instance (decay 1000)
  logic       rst_a = 1'b0, exec_a = 1'b0;
  logic [1:0] sel_a = 2'b00;
  logic       st_a, busy_a, na_a;
  logic [3:0] f_a, h_a, c_a;
  // DUT B: fast decay (10)
  logic       rst_b = 1'b0, exec_b = 1'b0;
  logic [1:0] sel_b = 2'b00;
  logic       st_b, busy_b, na_b;
  logic [3:0] f_b, h_b, c_b;
  // DUT C: decay 6 for the coincidence case
  logic       rst_c = 1'b0, exec_c = 1'b0;
  logic [1:0] sel_c = 2'b00;
  logic       st_c, busy_c, na_c;
  logic [3:0] f_c, h_c, c_c;

  companion_action_exec #(.ACTION_CYCLES(AC), .DECAY_CYCLES(DEC_A)) dut_a (
    .clk(clk), .rst(rst_a), .selected(sel_a), .exec(exec_a), .exec_status(st_a), .busy(busy_a),
    .fullness(f_a), .happiness(h_a), .cleanliness(c_a), .needs_attention(na_a));
  companion_action_exec #(.ACTION_CYCLES(AC), .DECAY_CYCLES(DEC_B)) dut_b (
    .clk(clk), .rst(rst_b), .selected(sel_b), .exec(exec_b), .exec_status(st_b), .busy(busy_b),
    .fullness(f_b), .happiness(h_b), .cleanliness(c_b), .needs_attention(na_b));
  companion_action_exec #(.ACTION_CYCLES(AC), .DECAY_CYCLES(DEC_C)) dut_c (
    .clk(clk), .rst(rst_c), .selected(sel_c), .exec(exec_c), .exec_status(st_c), .busy(busy_c),
    .fullness(f_c), .happiness(h_c), .cleanliness(c_c), .needs_attention(na_c));

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
  endfunction

  // ---------------- reference model for DUT A ----------------
  // Edges are numbered from 1 after reset release. An action whose exec is
  // sampled on edge s completes on edge s+AC; decay hits on every edge that is
  // a multiple of DEC_A. Effects on one edge are summed, then clamped.
  int m_edge = 0, m_f = 8, m_h = 8, m_c = 8;
  bit m_na = 1'b0;
  int act_start = -1000;
  int act_sel   = 0;
  bit chk_en    = 1'b0;

  always @(posedge clk) begin : model
    int en, f, h, c, dk;
    if (!rst_a) begin
      m_edge <= 0;
      m_f <= 8; m_h <= 8; m_c <= 8;
      m_na <= 1'b0;
    end else begin
      en = m_edge + 1;
      dk = (en % DEC_A == 0) ? 1 : 0;
      f = m_f - dk; h = m_h - dk; c = m_c - dk;
      if (en == act_start + AC) begin
        case (act_sel)
          1: f = f + 4;
          2: begin h = h + 4; f = f - 1; end
          3: c = c + 4;
          default: ;
        endcase
      end
      m_na   <= (m_f < 3) || (m_h < 3) || (m_c < 3);
      m_f    <= clamp(f);
      m_h    <= clamp(h);
      m_c    <= clamp(c);
      m_edge <= en;
    end
  end

  // Cycle-by-cycle comparison of DUT A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_fullness",    32'(f_a),    32'(m_f));
      check("model_happiness",   32'(h_a),    32'(m_h));
      check("model_cleanliness", 32'(c_a),    32'(m_c));
      check("model_busy",        32'(busy_a), 32'((m_edge >= act_start) && (m_edge <= act_start + AC - 1)));
      check("model_exec_status", 32'(st_a),   32'(m_edge == act_start + AC));
      check("model_attention",   32'(na_a),   32'(m_na));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0; exec_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    act_start = -1000;
    check("reset_fullness",    32'(f_a), 32'd8);
    check("reset_happiness",   32'(h_a), 32'd8);
    check("reset_cleanliness", 32'(c_a), 32'd8);
    check("reset_exec_status", 32'(st_a), 32'd0);
    check("reset_busy",        32'(busy_a), 32'd0);
    check("reset_attention",   32'(na_a), 32'd0);
    chk_en = 1'b1;
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    @(negedge clk);
    rst_b = 1'b0; exec_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic reset_c();
    @(negedge clk);
    rst_c = 1'b0; exec_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_c = 1'b1;
  endtask

  // One request on DUT A: raise exec, scramble selected while running, wait for
  // the pulse, keep exec high for 'hold' more cycles, release. Called at a negedge.
  task automatic do_action(input logic [1:0] sel, input int hold);
    int pulses = 0;
    int waited = 0;
    bit seen   = 1'b0;
    sel_a = sel; exec_a = 1'b1;
    act_start = m_edge + 1; act_sel = int'(sel);
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      sel_a = 2'($urandom_range(0, 3));
      if (st_a === 1'b1) begin
        seen = 1'b1;
        pulses++;
      end
    end
    if (!seen) check("exec_status_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (st_a === 1'b1) pulses++;
    end
    exec_a = 1'b0;
    @(negedge clk);
    if (st_a === 1'b1) pulses++;
    check("pulse_count", 32'(pulses), 32'd1);
    $display("action sel=%0d hold=%0d latency=%0d full=%0d happy=%0d clean=%0d",
             sel, hold, waited, f_a, h_a, c_a);
  endtask

  typedef struct {
    bit         do_rst;
    logic [1:0] sel;
    int         hold;
    int         ef, eh, ec;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int cnt_busy, cnt_st;

    tbl[0] = '{1'b1, 2'b01, 2, 12,  8,  8};  // feed, exec held: one pulse
    tbl[1] = '{1'b0, 2'b10, 0, 11, 12,  8};  // play: happy up, fullness cost
    tbl[2] = '{1'b1, 2'b01, 0, 12,  8,  8};  // feed from reset
    tbl[3] = '{1'b0, 2'b01, 1, 15,  8,  8};  // feed saturates
    tbl[4] = '{1'b0, 2'b01, 0, 15,  8,  8};  // feed stays saturated
    tbl[5] = '{1'b0, 2'b11, 0, 15,  8, 12};  // clean
    tbl[6] = '{1'b0, 2'b00, 0, 15,  8, 12};  // none: no change, still completes

    // Reset state and table-driven actions on DUT A
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_rst) reset_a();
      do_action(tbl[i].sel, tbl[i].hold);
      check("tbl_fullness",    32'(f_a), 32'(tbl[i].ef));
      check("tbl_happiness",   32'(h_a), 32'(tbl[i].eh));
      check("tbl_cleanliness", 32'(c_a), 32'(tbl[i].ec));
    end

    // Decay to the floor on DUT B
    reset_b();
    wait_edges(59);
    check("decay_59_fullness", 32'(f_b), 32'd3);
    check("decay_59_attention", 32'(na_b), 32'd0);
    wait_edges(1);
    check("decay_60_fullness",    32'(f_b), 32'd2);
    check("decay_60_happiness",   32'(h_b), 32'd2);
    check("decay_60_cleanliness", 32'(c_b), 32'd2);
    check("decay_60_attention",   32'(na_b), 32'd0);
    wait_edges(1);
    check("decay_61_attention", 32'(na_b), 32'd1);
    wait_edges(19);
    check("decay_80_fullness",    32'(f_b), 32'd0);
    check("decay_80_happiness",   32'(h_b), 32'd0);
    check("decay_80_cleanliness", 32'(c_b), 32'd0);
    wait_edges(20);
    check("decay_100_fullness", 32'(f_b), 32'd0);
    check("decay_100_attention", 32'(na_b), 32'd1);
    $display("decay run done full=%0d happy=%0d clean=%0d", f_b, h_b, c_b);

    // Completion coinciding with the decay wrap on DUT C
    reset_c();
    @(posedge clk);
    @(negedge clk);
    sel_c = 2'b01; exec_c = 1'b1;
    wait_edges(4);
    check("coinc_busy_before",   32'(busy_c), 32'd1);
    check("coinc_status_before", 32'(st_c),   32'd0);
    check("coinc_full_before",   32'(f_c),    32'd8);
    wait_edges(1);
    check("coinc_status",      32'(st_c),   32'd1);
    check("coinc_busy",        32'(busy_c), 32'd0);
    check("coinc_fullness",    32'(f_c),    32'd11);
    check("coinc_happiness",   32'(h_c),    32'd7);
    check("coinc_cleanliness", 32'(c_c),    32'd7);
    exec_c = 1'b0;
    $display("coincidence run done full=%0d happy=%0d", f_c, h_c);

    // Reset in the second RUN cycle on DUT A
    reset_a();
    sel_a = 2'b01; exec_a = 1'b1;
    act_start = m_edge + 1; act_sel = 1;
    @(negedge clk);
    check("abort_busy_run1", 32'(busy_a), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    act_start = -1000;
    rst_a = 1'b1; exec_a = 1'b0;
    cnt_busy = 0; cnt_st = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) cnt_busy++;
      if (st_a === 1'b1) cnt_st++;
    end
    check("abort_busy_count",   32'(cnt_busy), 32'd0);
    check("abort_status_count", 32'(cnt_st),   32'd0);
    check("abort_fullness",     32'(f_a),      32'd8);
    $display("abort run done full=%0d busy=%0d", f_a, busy_a);

    // Randomized actions on DUT A against the model
    reset_a();
    for (int n = 0; n < 150; n++) begin
      do_action(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
